apb_master: RTL and testbench
=============================

# apb_master

Single-outstanding APB requester that turns a valid/ready command stream into APB setup/access transfers and returns read data and error status on a valid/ready response channel. It is the initiator side for the team's APB-slave peripherals (interrupt controller priority registers, etc.), used by bench-less integrations and the processor-side glue that programs those peripherals.

## Interface
- ADDR_WIDTH, 4, APB address width
- DATA_WIDTH, 4, APB data width
- TIMEOUT_CYCLES, 16, max ACCESS wait cycles before abort (used only with timeout enabled; must be ≥1)

- pclk_i  in  1  clock; all logic on rising edge
- prst_i  in  1  reset, synchronous, active-low
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted this cycle when high with cmd_valid_i
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  ADDR_WIDTH  target address
- cmd_wdata_i  in  DATA_WIDTH  write data
- rsp_valid_o  out  1  response available
- rsp_ready_i  in  1  response consumed
- rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes)
- rsp_error_o  out  1  slave perror or timeout
- rsp_timeout_o  out  1  response terminated by timeout
- psel_o, penable_o, pwrite_o  out  1  APB control
- paddr_o  out  ADDR_WIDTH  APB address
- pwdata_o  out  DATA_WIDTH  APB write data
- prdata_i  in  DATA_WIDTH  APB read data
- pready_i, perror_i  in  1  APB completion / error

## Operation
- FSM: IDLE, SETUP, ACCESS, RESP. Reset → IDLE.
- IDLE: cmd_ready_o=1. On cmd_valid_i: latch write/addr/wdata into paddr_o/pwrite_o/pwdata_o, → SETUP.
- SETUP: psel_o=1, penable_o=0, → ACCESS unconditionally.
- ACCESS: psel_o=1, penable_o=1. If pready_i: capture rsp_rdata_o = pwrite ? 0 : prdata_i, rsp_error_o = perror_i, rsp_timeout_o=0, → RESP. Else stay (wait state).
- RESP: rsp_valid_o=1, psel_o=penable_o=0; response fields held stable until rsp_ready_i; then → IDLE.
- cmd_ready_o is 0 in every state except IDLE; only one transfer outstanding.
- paddr_o/pwrite_o/pwdata_o stable from SETUP through ACCESS completion; hold last value otherwise.
- perror_i ignored unless sampled with pready_i in ACCESS.

## Timing
- Reset values: all outputs 0 except cmd_ready_o, which is 0 during reset cycle and 1 first cycle after release (IDLE).
- Command accepted at edge t → SETUP in t+1, ACCESS in t+2; zero-wait pready → rsp_valid_o in t+3. Each wait state adds one cycle.
- rsp_ready_i high in cycle of first rsp_valid_o → IDLE next cycle; next command earliest accepted then (min 4 cycles per transfer).
- Reset asserted mid-transfer: next edge forces IDLE, psel_o/penable_o=0, pending response discarded, no rsp_valid_o.
- pready_i outside ACCESS has no effect.

## Configuration
- APB_MASTER_TIMEOUT_EN defined: counter of width $clog2(TIMEOUT_CYCLES+1) clears on SETUP, increments each ACCESS cycle with pready_i=0. When it reaches TIMEOUT_CYCLES with pready_i still 0: drop psel_o/penable_o, → RESP with rsp_error_o=1, rsp_timeout_o=1, rsp_rdata_o=0. pready_i=1 in the same cycle wins (normal completion).
- Not defined: no counter; ACCESS waits indefinitely; rsp_timeout_o tied 0.

## Test plan
- Write addr 4'h3 data 4'hA, pready_i=1 immediately → psel_o t+1, penable_o t+2, paddr_o=3, pwdata_o=A, rsp_valid_o t+3, rsp_error_o=0, rsp_rdata_o=0.
- Read addr 4'h5, pready_i low 3 cycles then high with prdata_i=4'h6 → ACCESS lasts 4 cycles, rsp_rdata_o=6, paddr_o stable throughout.
- Read with pready_i=1, perror_i=1 → rsp_error_o=1, rsp_timeout_o=0; rsp_ready_i held low 5 cycles → rsp_valid_o and fields stable, cmd_ready_o=0.
- Back-to-back commands (cmd_valid_i held, rsp_ready_i=1) → second accepted only after IDLE return; 4-cycle spacing; no overlap of psel_o.
- prst_i=0 during ACCESS → next cycle psel_o=penable_o=0, rsp_valid_o never asserted, cmd_ready_o=1 after release.
- With APB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready_i stuck 0 → abort after 16 ACCESS cycles, rsp_error_o=1, rsp_timeout_o=1; without macro, still waiting at cycle 100.

Source files
------------

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester.
// Converts a valid/ready command stream into APB setup/access transfers and
// returns read data and error status on a valid/ready response channel.
// Optional ACCESS-phase timeout is compiled in with `define APB_MASTER_TIMEOUT_EN;
// without it ACCESS waits for pready_i indefinitely and rsp_timeout_o is tied 0.
module apb_master #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk_i,
  input  logic                  prst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_error_o,
  output logic                  rsp_timeout_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [DATA_WIDTH-1:0] pwdata_o,
  input  logic [DATA_WIDTH-1:0] prdata_i,
  input  logic                  pready_i,
  input  logic                  perror_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_error
    $error("apb_master: TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state, state_next;

  logic accept;   // command handshake this cycle
  logic done;     // slave completed the access phase
  logic abort;    // access phase terminated by timeout

  assign accept = (state == IDLE) && cmd_valid_i;
  assign done   = (state == ACCESS) && pready_i;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;

  // The cycle that would take the count to TIMEOUT_CYCLES is the last ACCESS
  // cycle; a simultaneous pready_i still completes normally.
  assign abort = (state == ACCESS) && !pready_i &&
                 (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count ACCESS wait states, restarting at every SETUP
  always_ff @(posedge pclk_i) begin
    if (!prst_i) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if ((state == ACCESS) && !pready_i) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Record whether the held response was produced by a timeout
  always_ff @(posedge pclk_i) begin
    if (!prst_i) begin
      timeout_q <= 1'b0;
    end else if (done) begin
      timeout_q <= 1'b0;
    end else if (abort) begin
      timeout_q <= 1'b1;
    end
  end

  assign rsp_timeout_o = timeout_q;
`else
  assign abort         = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  // State register
  always_ff @(posedge pclk_i) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    if (!prst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid_i)         state_next = SETUP;
      SETUP:                            state_next = ACCESS;
      ACCESS:  if (pready_i || abort)   state_next = RESP;
      RESP:    if (rsp_ready_i)         state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  // Control outputs decoded from state; cmd_ready_o is held low while in reset
  always_comb begin
    cmd_ready_o = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (state)
      IDLE:    cmd_ready_o = prst_i;
      SETUP:   psel_o      = 1'b1;
      ACCESS:  begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
      end
      RESP:    rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Request latch on accept, response capture on completion or abort
  always_ff @(posedge pclk_i) begin
    // NOTE: these plain registers (no memory arrays here) are reset so every
    // output reads 0 coming out of reset.
    if (!prst_i) begin
      pwrite_o    <= 1'b0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
    end else begin
      if (accept) begin
        pwrite_o <= cmd_write_i;
        paddr_o  <= cmd_addr_i;
        pwdata_o <= cmd_wdata_i;
      end
      if (done) begin
        rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
        rsp_error_o <= perror_i;
      end else if (abort) begin
        rsp_rdata_o <= '0;
        rsp_error_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master: directed commands against a small APB slave model.
// Expected responses and APB requests go into queues when a command is issued;
// separate monitors pop and compare them when the DUT presents them.
module tb_apb_master;

  localparam int AW = 4;
  localparam int DW = 4;
  localparam int TO = 16;
  localparam int STUCK = 1000000;

  logic          pclk_i = 1'b0;
  logic          prst_i = 1'b0;
  logic          cmd_valid_i = 1'b0;
  logic          cmd_ready_o;
  logic          cmd_write_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [DW-1:0] cmd_wdata_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b1;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_error_o;
  logic          rsp_timeout_o;
  logic          psel_o;
  logic          penable_o;
  logic          pwrite_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic [DW-1:0] prdata_i = '0;
  logic          pready_i = 1'b0;
  logic          perror_i = 1'b0;

  apb_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk_i       (pclk_i),
    .prst_i       (prst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_write_i  (cmd_write_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_error_o  (rsp_error_o),
    .rsp_timeout_o(rsp_timeout_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .pwrite_o     (pwrite_o),
    .paddr_o      (paddr_o),
    .pwdata_o     (pwdata_o),
    .prdata_i     (prdata_i),
    .pready_i     (pready_i),
    .perror_i     (perror_i)
  );

  always #5 pclk_i = ~pclk_i;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge pclk_i) cyc <= cyc + 1;

  logic [5:0] rsp_q[$];     // {rdata, error, timeout}
  logic [8:0] apb_q[$];     // {addr, write, wdata}
  int         accept_cyc[$];

  // Slave model knobs
  int         slv_wait  = 0;
  logic [3:0] slv_rdata = '0;
  logic       slv_err   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge pclk_i);
    #1;
  endtask

  // APB slave: inserts slv_wait wait states, then completes; garbage elsewhere
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    forever begin
      @(negedge pclk_i);
      if (psel_o && penable_o) begin
        pready_i = (acc_cnt == slv_wait);
        prdata_i = pready_i ? slv_rdata : 4'hE;
        perror_i = pready_i ? slv_err : 1'b1;
        acc_cnt++;
      end else begin
        acc_cnt  = 0;
        pready_i = 1'b0;
        prdata_i = 4'hD;
        perror_i = 1'b1;
      end
    end
  end

  // Monitors: response handshake, APB completion, command acceptance
  initial begin
    logic [5:0] er;
    logic [8:0] ea;
    forever begin
      @(negedge pclk_i);
      #1;
      if (prst_i && rsp_valid_o && rsp_ready_i) begin
        if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else begin
          er = rsp_q.pop_front();
          check("rsp_fields", {rsp_rdata_o, rsp_error_o, rsp_timeout_o}, er);
        end
      end
      if (prst_i && psel_o && penable_o && pready_i) begin
        if (apb_q.size() == 0) check("apb_unexpected", 1, 0);
        else begin
          ea = apb_q.pop_front();
          check("apb_request", {paddr_o, pwrite_o, pwdata_o}, ea);
        end
      end
      if (prst_i && cmd_valid_i && cmd_ready_o) accept_cyc.push_back(cyc);
    end
  end

  // Issue one command and follow it through to the response handshake
  task automatic run_cmd(input logic wr, input logic [3:0] a, input logic [3:0] d,
                         input int wt, input logic [3:0] rd, input logic er,
                         input logic [5:0] exp_rsp, input int exp_lat,
                         input int hold, input logic push_apb);
    int n;
    slv_wait  = wt;
    slv_rdata = rd;
    slv_err   = er;
    rsp_q.push_back(exp_rsp);
    if (push_apb) apb_q.push_back({a, wr, d});
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = a;
    cmd_wdata_i = d;
    rsp_ready_i = (hold == 0);
    check("idle_ready", cmd_ready_o, 1);
    tick();
    cmd_valid_i = 1'b0;
    cmd_wdata_i = ~d;
    cmd_addr_i  = ~a;
    check("setup_ctrl", {psel_o, penable_o, cmd_ready_o}, 3'b100);
    n = 0;
    while (!rsp_valid_o && n < 100) begin
      check("req_stable", {paddr_o, pwrite_o, pwdata_o}, {a, wr, d});
      tick();
      n++;
    end
    if (!rsp_valid_o) begin
      check("rsp_arrive", 0, 1);
      return;
    end
    check("latency", n, exp_lat);
    check("resp_ctrl", {psel_o, penable_o, cmd_ready_o}, 3'b000);
    for (int i = 0; i < hold; i++) begin
      check("hold_fields", {rsp_valid_o, cmd_ready_o, rsp_rdata_o, rsp_error_o, rsp_timeout_o},
            {1'b1, 1'b0, exp_rsp});
      tick();
    end
    rsp_ready_i = 1'b1;
    tick();
    check("back_idle", {cmd_ready_o, rsp_valid_o}, 2'b10);
  endtask

  initial begin
    int n;
    // Reset state
    tick();
    tick();
    check("reset_ctrl", {cmd_ready_o, psel_o, penable_o, rsp_valid_o}, 4'b0000);
    check("reset_data", {paddr_o, pwdata_o, pwrite_o, rsp_rdata_o, rsp_error_o, rsp_timeout_o},
          15'h0);
    prst_i = 1'b1;
    tick();
    check("ready_after_rst", cmd_ready_o, 1);

    // Zero-wait write 3/A
    run_cmd(1'b1, 4'h3, 4'hA, 0, 4'h7, 1'b0, 6'b0000_0_0, 2, 0, 1'b1);
    // Read 5 with 3 wait states returning 6
    run_cmd(1'b0, 4'h5, 4'h1, 3, 4'h6, 1'b0, 6'b0110_0_0, 5, 0, 1'b1);
    // Read with slave error, response back-pressured for 5 cycles
    run_cmd(1'b0, 4'hC, 4'h0, 0, 4'hB, 1'b1, 6'b1011_1_0, 2, 5, 1'b1);
    // Write with error: read data forced to 0
    run_cmd(1'b1, 4'h0, 4'hF, 1, 4'h9, 1'b1, 6'b0000_1_0, 3, 0, 1'b1);

    // Back-to-back with cmd_valid_i held
    accept_cyc.delete();
    slv_wait = 0; slv_rdata = 4'h9; slv_err = 1'b0; rsp_ready_i = 1'b1;
    rsp_q.push_back(6'b0000_0_0);
    apb_q.push_back({4'h1, 1'b1, 4'h2});
    rsp_q.push_back(6'b1001_0_0);
    apb_q.push_back({4'h7, 1'b0, 4'h4});
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 4'h1; cmd_wdata_i = 4'h2;
    tick();
    cmd_write_i = 1'b0; cmd_addr_i = 4'h7; cmd_wdata_i = 4'h4;
    n = 0;
    while (!cmd_ready_o && n < 10) begin
      tick();
      n++;
    end
    check("b2b_gap", n, 3);
    tick();
    cmd_valid_i = 1'b0;
    n = 0;
    while (!cmd_ready_o && n < 10) begin
      tick();
      n++;
    end
    check("b2b_done", n, 3);
    check("b2b_accepts", accept_cyc.size(), 2);
    if (accept_cyc.size() == 2) check("b2b_spacing", accept_cyc[1] - accept_cyc[0], 4);

    // Reset asserted during ACCESS
    slv_wait = STUCK;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 4'h6;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    check("pre_rst_access", {psel_o, penable_o}, 2'b11);
    prst_i = 1'b0;
    tick();
    check("rst_bus_idle", {psel_o, penable_o, rsp_valid_o, cmd_ready_o}, 4'b0000);
    prst_i = 1'b1;
    tick();
    check("rst_release_ready", cmd_ready_o, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_rsp_after_rst", rsp_valid_o, 0);
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Stuck slave: abort after 16 ACCESS cycles
    run_cmd(1'b0, 4'h2, 4'h0, STUCK, 4'h0, 1'b0, 6'b0000_1_1, TO + 1, 0, 1'b0);
    // Timeout flag cleared by the next normal completion
    run_cmd(1'b0, 4'hF, 4'h0, 0, 4'h5, 1'b0, 6'b0101_0_0, 2, 0, 1'b1);
`else
    // Stuck slave: still waiting after 100 cycles
    slv_wait = STUCK;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 4'h2;
    tick();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    check("still_waiting", {psel_o, penable_o, rsp_valid_o}, 3'b110);
    prst_i = 1'b0;
    tick();
    prst_i = 1'b1;
    tick();
    check("stuck_recover", cmd_ready_o, 1);
`endif
    // Boundary address after recovery
    run_cmd(1'b1, 4'hF, 4'h5, 1, 4'h3, 1'b0, 6'b0000_0_0, 3, 0, 1'b1);

    tick();
    tick();
    check("rsp_q_empty", rsp_q.size(), 0);
    check("apb_q_empty", apb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
